// File: rtl/alu_cu_regfile.sv
// alu_cu_regfile: execute-stage decode, 32x32 register file with write bypass, and ALU
module alu_cu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        stall,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        zero,
    output logic [3:0]  alu_op,
    output logic [4:0]  shamt_o,
    output logic [1:0]  alu_src,
    output logic        regwrite,
    output logic        rdrt,
    output logic [1:0]  regsel,
    output logic        enhilo,
    output logic        memwrite,
    output logic        gpio_in_en,
    output logic        gpio_out_en
);
    logic [31:0] regs [32];
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, shamt;
    logic [15:0] imm;
    logic [31:0] b;
    logic        rw_d, hl_d, gi_d, go_d;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    // clear every register the moment reset asserts; otherwise take the write-back port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        else if (we && waddr != 5'd0)
            regs[waddr] <= wdata;
    end

    assign rdata1 = !rst ? '0 : rs == 5'd0 ? '0 : (we && waddr == rs) ? wdata : regs[rs];
    assign rdata2 = !rst ? '0 : rt == 5'd0 ? '0 : (we && waddr == rt) ? wdata : regs[rt];

    // instruction decode; anything unrecognised falls through to the all-disabled defaults
    always_comb begin
        alu_op  = 4'b0100;
        shamt_o = '0;
        alu_src = 2'b00;
        rdrt    = 1'b0;
        regsel  = 2'b00;
        rw_d    = 1'b0;
        hl_d    = 1'b0;
        gi_d    = 1'b0;
        go_d    = 1'b0;
        case (opcode)
            6'h00: case (funct)
                6'h20, 6'h21: rw_d = 1'b1;
                6'h22, 6'h23: begin alu_op = 4'b0101; rw_d = 1'b1; end
                6'h24: begin alu_op = 4'b0000; rw_d = 1'b1; end
                6'h25: begin alu_op = 4'b0001; rw_d = 1'b1; end
                6'h26: begin alu_op = 4'b0011; rw_d = 1'b1; end
                6'h27: begin alu_op = 4'b0010; rw_d = 1'b1; end
                6'h2A: begin alu_op = 4'b1100; rw_d = 1'b1; end
                6'h2B: begin alu_op = 4'b1101; rw_d = 1'b1; end
                6'h00: begin alu_op = 4'b1000; shamt_o = shamt; rw_d = 1'b1; end
                6'h02: begin alu_op = 4'b1001; shamt_o = shamt; rw_d = 1'b1; end
                6'h03: begin alu_op = 4'b1010; shamt_o = shamt; rw_d = 1'b1; end
                6'h18: begin alu_op = 4'b0110; hl_d = 1'b1; end
                6'h19: begin alu_op = 4'b0111; hl_d = 1'b1; end
                6'h10: begin regsel = 2'b01; rw_d = 1'b1; end
                6'h12: begin regsel = 2'b10; rw_d = 1'b1; end
                default: ;
            endcase
            6'h08, 6'h09: begin alu_src = 2'b01; rw_d = 1'b1; rdrt = 1'b1; end
            6'h0A: begin alu_op = 4'b1100; alu_src = 2'b01; rw_d = 1'b1; rdrt = 1'b1; end
            6'h0B: begin alu_op = 4'b1101; alu_src = 2'b01; rw_d = 1'b1; rdrt = 1'b1; end
            6'h0C: begin alu_op = 4'b0000; alu_src = 2'b10; rw_d = 1'b1; rdrt = 1'b1; end
            6'h0D: begin alu_op = 4'b0001; alu_src = 2'b10; rw_d = 1'b1; rdrt = 1'b1; end
            6'h0E: begin alu_op = 4'b0011; alu_src = 2'b10; rw_d = 1'b1; rdrt = 1'b1; end
            6'h0F: begin alu_op = 4'b1000; shamt_o = 5'd16; alu_src = 2'b10; rw_d = 1'b1; rdrt = 1'b1; end
            6'h10: begin
                go_d = funct == 6'h00;
                gi_d = funct == 6'h01;
                rw_d = funct == 6'h01;
                rdrt = funct == 6'h01;
            end
            default: ;
        endcase
    end

    assign regwrite    = rw_d & ~stall;
    assign enhilo      = hl_d & ~stall;
    assign gpio_in_en  = gi_d & ~stall;
    assign gpio_out_en = go_d & ~stall;
    assign memwrite    = 1'b0;

    assign b = alu_src == 2'b01 ? {{16{imm[15]}}, imm} : alu_src == 2'b10 ? {16'h0, imm} : rdata2;

    // ALU; hi is only meaningful for the two multiplies
    always_comb begin
        hi = '0;
        lo = '0;
        case (alu_op)
            4'b0000: lo = rdata1 & b;
            4'b0001: lo = rdata1 | b;
            4'b0010: lo = ~(rdata1 | b);
            4'b0011: lo = rdata1 ^ b;
            4'b0100: lo = rdata1 + b;
            4'b0101: lo = rdata1 - b;
            4'b0110: {hi, lo} = $signed(rdata1) * $signed(b);
            4'b0111: {hi, lo} = {32'h0, rdata1} * {32'h0, b};
            4'b1000: lo = b << shamt_o;
            4'b1001: lo = b >> shamt_o;
            4'b1010: lo = $signed(b) >>> shamt_o;
            4'b1100: lo = {31'h0, $signed(rdata1) < $signed(b)};
            4'b1101: lo = {31'h0, rdata1 < b};
            default: ;
        endcase
    end

    assign zero = lo == 32'h0;
endmodule

// File: tb/tb_alu_cu_regfile.sv
// tb_alu_cu_regfile: directed and randomized checks against an instruction-level reference model
module tb_alu_cu_regfile;
    logic        clk, rst, stall, we;
    logic [31:0] instr, wdata;
    logic [4:0]  waddr;
    logic [31:0] rdata1, rdata2, hi, lo;
    logic        zero, regwrite, rdrt, enhilo, memwrite, gpio_in_en, gpio_out_en;
    logic [3:0]  alu_op;
    logic [4:0]  shamt_o;
    logic [1:0]  alu_src, regsel;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m [32];

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  sh;
        logic [1:0]  src;
        logic        rw, rd_rt;
        logic [1:0]  rsel;
        logic        hl, gi, go;
        logic [31:0] hi, lo;
        logic        z;
    } exp_t;

    localparam logic [5:0] RFUN [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                         6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h10, 6'h12};
    localparam logic [5:0] IOP [9] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10};

    alu_cu_regfile dut (
        .clk(clk), .rst(rst), .instr(instr), .stall(stall), .we(we), .waddr(waddr), .wdata(wdata),
        .rdata1(rdata1), .rdata2(rdata2), .hi(hi), .lo(lo), .zero(zero), .alu_op(alu_op),
        .shamt_o(shamt_o), .alu_src(alu_src), .regwrite(regwrite), .rdrt(rdrt), .regsel(regsel),
        .enhilo(enhilo), .memwrite(memwrite), .gpio_in_en(gpio_in_en), .gpio_out_en(gpio_out_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (instr %h)", tag, got, exp, instr);
        end
    endtask

    function automatic logic [31:0] rv(input logic [4:0] a);
        return (!rst || a == 5'd0) ? 32'h0 : (we && waddr == a) ? wdata : m[a];
    endfunction

    function automatic logic [31:0] r_i(input logic [4:0] s, input logic [4:0] t, input logic [4:0] sh, input logic [5:0] f);
        return {6'h00, s, t, 5'd3, sh, f};
    endfunction

    function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] s, input logic [15:0] im);
        return {op, s, 5'd7, im};
    endfunction

    // expected outputs computed per instruction meaning, operands taken as architectural values
    function automatic exp_t model(input logic [31:0] i, input logic st, input logic [31:0] a, input logic [31:0] r);
        exp_t e;
        logic [31:0] se, ze;
        logic [4:0]  sa;
        logic signed [63:0] p;
        se = {{16{i[15]}}, i[15:0]};
        ze = {16'h0, i[15:0]};
        sa = i[10:6];
        e = '0;
        e.op = 4'b0100;
        e.lo = a + r;
        if (i[31:26] == 6'h00) begin
            case (i[5:0])
                6'h20, 6'h21: e.rw = 1;
                6'h22, 6'h23: begin e.op = 4'b0101; e.rw = 1; e.lo = a - r; end
                6'h24: begin e.op = 4'b0000; e.rw = 1; e.lo = a & r; end
                6'h25: begin e.op = 4'b0001; e.rw = 1; e.lo = a | r; end
                6'h26: begin e.op = 4'b0011; e.rw = 1; e.lo = a ^ r; end
                6'h27: begin e.op = 4'b0010; e.rw = 1; e.lo = ~(a | r); end
                6'h2A: begin e.op = 4'b1100; e.rw = 1; e.lo = ($signed(a) < $signed(r)) ? 1 : 0; end
                6'h2B: begin e.op = 4'b1101; e.rw = 1; e.lo = (a < r) ? 1 : 0; end
                6'h00: begin e.op = 4'b1000; e.sh = sa; e.rw = 1; e.lo = r << sa; end
                6'h02: begin e.op = 4'b1001; e.sh = sa; e.rw = 1; e.lo = r >> sa; end
                6'h03: begin e.op = 4'b1010; e.sh = sa; e.rw = 1; e.lo = $signed(r) >>> sa; end
                6'h18: begin
                    e.op = 4'b0110; e.hl = 1;
                    p = 64'(signed'(a)) * 64'(signed'(r));
                    {e.hi, e.lo} = p;
                end
                6'h19: begin e.op = 4'b0111; e.hl = 1; {e.hi, e.lo} = {32'h0, a} * {32'h0, r}; end
                6'h10: begin e.rsel = 2'b01; e.rw = 1; end
                6'h12: begin e.rsel = 2'b10; e.rw = 1; end
                default: ;
            endcase
        end else begin
            case (i[31:26])
                6'h08, 6'h09: begin e.src = 2'b01; e.rw = 1; e.rd_rt = 1; e.lo = a + se; end
                6'h0A: begin e.op = 4'b1100; e.src = 2'b01; e.rw = 1; e.rd_rt = 1; e.lo = ($signed(a) < $signed(se)) ? 1 : 0; end
                6'h0B: begin e.op = 4'b1101; e.src = 2'b01; e.rw = 1; e.rd_rt = 1; e.lo = (a < se) ? 1 : 0; end
                6'h0C: begin e.op = 4'b0000; e.src = 2'b10; e.rw = 1; e.rd_rt = 1; e.lo = a & ze; end
                6'h0D: begin e.op = 4'b0001; e.src = 2'b10; e.rw = 1; e.rd_rt = 1; e.lo = a | ze; end
                6'h0E: begin e.op = 4'b0011; e.src = 2'b10; e.rw = 1; e.rd_rt = 1; e.lo = a ^ ze; end
                6'h0F: begin e.op = 4'b1000; e.sh = 16; e.src = 2'b10; e.rw = 1; e.rd_rt = 1; e.lo = {i[15:0], 16'h0}; end
                6'h10: begin
                    e.go = i[5:0] == 6'h00;
                    e.gi = i[5:0] == 6'h01;
                    e.rw = e.gi;
                    e.rd_rt = e.gi;
                end
                default: ;
            endcase
        end
        e.z = e.lo == 0;
        if (st) begin e.rw = 0; e.hl = 0; e.gi = 0; e.go = 0; end
        return e;
    endfunction

    task automatic run(input logic [31:0] i, input logic st);
        exp_t e;
        instr = i;
        stall = st;
        #1;
        e = model(i, st, rv(i[25:21]), rv(i[20:16]));
        check("rdata1", 64'(rdata1), 64'(rv(i[25:21])));
        check("rdata2", 64'(rdata2), 64'(rv(i[20:16])));
        check("alu_op", 64'(alu_op), 64'(e.op));
        check("shamt_o", 64'(shamt_o), 64'(e.sh));
        check("alu_src", 64'(alu_src), 64'(e.src));
        check("regwrite", 64'(regwrite), 64'(e.rw));
        check("rdrt", 64'(rdrt), 64'(e.rd_rt));
        check("regsel", 64'(regsel), 64'(e.rsel));
        check("enhilo", 64'(enhilo), 64'(e.hl));
        check("gpio_in", 64'(gpio_in_en), 64'(e.gi));
        check("gpio_out", 64'(gpio_out_en), 64'(e.go));
        check("memwrite", 64'(memwrite), 64'h0);
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("zero", 64'(zero), 64'(e.z));
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1; waddr = a; wdata = d;
        @(posedge clk);
        if (a != 0) m[a] = d;
        @(negedge clk);
        we = 0;
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] i;
        int k;
        i = $urandom;
        k = $urandom_range(0, 9);
        if (k < 5) begin
            i[31:26] = 6'h00;
            i[5:0] = RFUN[$urandom_range(0, 16)];
        end else if (k < 9) begin
            i[31:26] = IOP[$urandom_range(0, 8)];
            if (i[31:26] == 6'h10) i[5:0] = 6'($urandom_range(0, 2));
        end
        return i;
    endfunction

    initial begin
        rst = 0; we = 0; waddr = 0; wdata = 0; instr = 0; stall = 0;
        for (int i = 0; i < 32; i++) m[i] = 0;
        #12;
        run(r_i(5, 7, 0, 6'h21), 0);
        check("rst_rdata1", 64'(rdata1), 64'h0);
        @(negedge clk);
        rst = 1;
        wr(5, 32'h12345678);
        run(r_i(5, 0, 0, 6'h21), 0);
        check("reg5", 64'(rdata1), 64'h12345678);
        wr(0, 32'hFFFFFFFF);
        run(r_i(0, 0, 0, 6'h21), 0);
        check("reg0", 64'(rdata1), 64'h0);
        @(negedge clk);
        we = 1; waddr = 9; wdata = 32'hCAFEF00D;
        run(r_i(9, 9, 0, 6'h24), 0);
        check("bypass", 64'(rdata2), 64'hCAFEF00D);
        @(posedge clk);
        m[9] = 32'hCAFEF00D;
        @(negedge clk);
        we = 0;
        wr(1, 32'hFFFFFFFF); wr(2, 32'h1);
        run(r_i(1, 2, 0, 6'h21), 0);
        check("addu_lo", 64'(lo), 64'h0);
        check("addu_zero", 64'(zero), 64'h1);
        wr(1, 32'hFFFFFFFE); wr(2, 32'h3);
        run(r_i(1, 2, 0, 6'h18), 0);
        check("mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        run(r_i(1, 2, 0, 6'h19), 0);
        check("multu_hi", 64'(hi), 64'h2);
        wr(4, 32'h80000000);
        run(r_i(0, 4, 4, 6'h03), 0);
        check("sra", 64'(lo), 64'hF8000000);
        run(i_i(6'h0F, 0, 16'hABCD), 0);
        check("lui", 64'(lo), 64'hABCD0000);
        wr(1, 32'hFFFFFFFB);
        run(i_i(6'h0A, 1, 16'hFFFF), 0);
        check("slti", 64'(lo), 64'h1);
        wr(1, 32'hFFFFFFFF);
        run(i_i(6'h0C, 1, 16'h8000), 0);
        check("andi", 64'(lo), 64'h00008000);
        run(i_i(6'h10, 1, 16'h0001), 1);
        check("gpio_stall", 64'({gpio_in_en, regwrite}), 64'h0);
        run(i_i(6'h10, 1, 16'h0001), 0);
        run(i_i(6'h10, 1, 16'h0000), 0);
        run(32'hFC00_0000, 0);
        for (int i = 1; i < 32; i++) wr(5'(i), rnd());
        repeat (400) begin
            @(negedge clk);
            we = 1'($urandom_range(0, 1)); waddr = 5'($urandom); wdata = rnd();
            run(gen(), $urandom_range(0, 7) == 0);
            @(posedge clk);
            if (we && waddr != 0) m[waddr] = wdata;
        end
        @(negedge clk);
        we = 0;
        #2;
        rst = 0;
        #1;
        check("async_rst", 64'(rdata1), 64'h0);
        for (int i = 0; i < 32; i++) m[i] = 0;
        for (int i = 1; i < 32; i += 5) run(r_i(5'(i), 5'(31 - i), 0, 6'h20), 0);
        @(negedge clk);
        we = 1; waddr = 9; wdata = 32'h55AA55AA;
        @(posedge clk);
        @(negedge clk);
        we = 0;
        rst = 1;
        run(r_i(9, 9, 0, 6'h21), 0);
        check("rst_blocks_wr", 64'(rdata1), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
